fix_msg_delimiter: RTL and testbench

- Upstream framing stage of the FIX parser.
- Accepts the raw FIX byte stream one byte per cycle and writes in-message bytes into the circular message buffer.
- Detects message start (tag "8=") and message end (checksum field "10=ddd<SOH>").
- Emits start/end pulses with buffer addresses to the message location controller, which records message boundaries.

---
 rtl/fix_pkg.sv | 32 +++
 rtl/fix_wr_ptr.sv | 63 ++++++
 rtl/fix_msg_delimiter.sv | 184 ++++++++++++++++++
 tb/tb_fix_msg_delimiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - shared constants, state enum and helpers for the FIX framing stage
package fix_pkg;

  localparam logic [7:0] SOH      = 8'h01;
  localparam logic [7:0] ASCII_8  = 8'h38;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_0  = 8'h30;

  typedef enum logic [2:0] {
    HUNT,
    EQ,
    BODY,
    T1,
    T10,
    TEQ,
    CK,
    TERM
  } delim_state_t;

  // Write-pointer operations requested by the framing FSM
  localparam logic [2:0] PTR_HOLD    = 3'd0;
  localparam logic [2:0] PTR_START   = 3'd1;
  localparam logic [2:0] PTR_RESTART = 3'd2;
  localparam logic [2:0] PTR_ADVANCE = 3'd3;
  localparam logic [2:0] PTR_REWIND  = 3'd4;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/fix_wr_ptr.sv
// rtl/fix_wr_ptr.sv - buffer write pointer, message start address and saturating length
module fix_wr_ptr
  import fix_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int LEN_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            op_i,
  output logic [DATA_WIDTH-1:0] wp_o,
  output logic [DATA_WIDTH-1:0] sa_o,
  output logic [LEN_W-1:0]      len_o
);

  logic [DATA_WIDTH-1:0] wp_q, wp_d;
  logic [DATA_WIDTH-1:0] sa_q, sa_d;
  logic [LEN_W-1:0]      len_q, len_d;

  always_comb begin
    wp_d  = wp_q;
    sa_d  = sa_q;
    len_d = len_q;
    case (op_i)
      PTR_START: begin
        sa_d  = wp_q;
        wp_d  = wp_q + DATA_WIDTH'(1);
        len_d = LEN_W'(1);
      end
      // A repeated '8' overwrites the first one, so the message restarts at sa
      PTR_RESTART: begin
        wp_d  = sa_q + DATA_WIDTH'(1);
        len_d = LEN_W'(1);
      end
      PTR_ADVANCE: begin
        wp_d = wp_q + DATA_WIDTH'(1);
        if (len_q != '1) len_d = len_q + LEN_W'(1);
      end
      PTR_REWIND: begin
        wp_d  = sa_q;
        len_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      sa_q  <= '0;
      len_q <= '0;
    end else begin
      wp_q  <= wp_d;
      sa_q  <= sa_d;
      len_q <= len_d;
    end
  end

  assign wp_o  = wp_q;
  assign sa_o  = sa_q;
  assign len_o = len_q;

endmodule

// File: rtl/fix_msg_delimiter.sv
// rtl/fix_msg_delimiter.sv - FIX byte-stream framer: buffer writes plus start/end/error pulses
module fix_msg_delimiter
  import fix_pkg::*;
#(
  parameter int DATA_WIDTH  = 5,
  parameter int MAX_MSG_LEN = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  ready_o,
  input  logic                  full_i,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_addr_o,
  output logic [7:0]            wr_data_o,
  output logic                  start_message_o,
  output logic [DATA_WIDTH-1:0] start_addr_o,
  output logic                  end_message_o,
  output logic [DATA_WIDTH-1:0] end_addr_o,
  output logic                  error_o
);

  localparam int LEN_W = $clog2(MAX_MSG_LEN + 2);

  delim_state_t          state_q, state_d;
  logic [1:0]            dc_q, dc_d;
  logic [2:0]            ptr_op;
  logic [DATA_WIDTH-1:0] wp, sa;
  logic [LEN_W-1:0]      len;
  logic                  accept, oversize;
  logic                  wr_d, start_d, end_d, err_d;
  logic [DATA_WIDTH-1:0] wr_addr_d;

  logic                  wr_en_q, start_q, end_q, err_q;
  logic [DATA_WIDTH-1:0] wr_addr_q, start_addr_q, end_addr_q;
  logic [7:0]            wr_data_q;

  fix_wr_ptr #(
    .DATA_WIDTH(DATA_WIDTH),
    .LEN_W     (LEN_W)
  ) u_wr_ptr (
    .clk  (clk),
    .rst  (rst),
    .op_i (ptr_op),
    .wp_o (wp),
    .sa_o (sa),
    .len_o(len)
  );

  assign ready_o  = ~full_i;
  assign accept   = byte_valid_i & ~full_i;
  assign oversize = len >= LEN_W'(MAX_MSG_LEN);

  always_comb begin
    state_d   = state_q;
    dc_d      = dc_q;
    ptr_op    = PTR_HOLD;
    wr_d      = 1'b0;
    wr_addr_d = wp;
    start_d   = 1'b0;
    end_d     = 1'b0;
    err_d     = 1'b0;
    if (accept) begin
      case (state_q)
        HUNT: begin
          if (byte_i == ASCII_8) begin
            wr_d    = 1'b1;
            ptr_op  = PTR_START;
            state_d = EQ;
          end
        end
        EQ: begin
          if (byte_i == ASCII_EQ) begin
            wr_d    = 1'b1;
            ptr_op  = PTR_ADVANCE;
            start_d = 1'b1;
            state_d = BODY;
          end else if (byte_i == ASCII_8) begin
            wr_d      = 1'b1;
            wr_addr_d = sa;
            ptr_op    = PTR_RESTART;
          end else begin
            ptr_op  = PTR_REWIND;
            state_d = HUNT;
          end
        end
        default: begin
          // Every in-message byte is written unless it breaks the trailer or the length limit
          if (oversize) begin
            err_d = 1'b1;
          end else begin
            wr_d = 1'b1;
            case (state_q)
              BODY: if (byte_i == SOH) state_d = T1;
              T1: begin
                if (byte_i == ASCII_1) state_d = T10;
                else if (byte_i != SOH) state_d = BODY;
              end
              T10: begin
                if (byte_i == ASCII_0) state_d = TEQ;
                else if (byte_i == SOH) state_d = T1;
                else state_d = BODY;
              end
              TEQ: begin
                if (byte_i == ASCII_EQ) begin
                  state_d = CK;
                  dc_d    = 2'd0;
                end else if (byte_i == SOH) begin
                  state_d = T1;
                end else begin
                  state_d = BODY;
                end
              end
              CK: begin
                if (is_digit(byte_i)) begin
                  dc_d = dc_q + 2'd1;
                  if (dc_q == 2'd2) state_d = TERM;
                end else begin
                  wr_d  = 1'b0;
                  err_d = 1'b1;
                end
              end
              TERM: begin
                if (byte_i == SOH) begin
                  end_d   = 1'b1;
                  state_d = HUNT;
                end else begin
                  wr_d  = 1'b0;
                  err_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
          if (err_d) begin
            ptr_op  = PTR_REWIND;
            state_d = HUNT;
          end else if (wr_d) begin
            ptr_op = PTR_ADVANCE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      dc_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      start_q      <= 1'b0;
      start_addr_q <= '0;
      end_q        <= 1'b0;
      end_addr_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      dc_q    <= dc_d;
      wr_en_q <= wr_d;
      start_q <= start_d;
      end_q   <= end_d;
      err_q   <= err_d;
      if (wr_d) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= byte_i;
      end
      if (start_d) start_addr_q <= sa;
      if (end_d) end_addr_q <= wp;
    end
  end

  assign wr_en_o         = wr_en_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;
  assign start_message_o = start_q;
  assign start_addr_o    = start_addr_q;
  assign end_message_o   = end_q;
  assign end_addr_o      = end_addr_q;
  assign error_o         = err_q;

endmodule

// File: tb/tb_fix_msg_delimiter.sv
// tb/tb_fix_msg_delimiter.sv - randomized and directed bench with a message-level reference model
module tb_fix_msg_delimiter;
  import fix_pkg::*;

  localparam int DW   = 5;
  localparam int MAXL = 24;
  localparam int NBUF = 1 << DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_i = '0;
  logic          byte_valid_i = 1'b0;
  logic          full_i = 1'b0;
  logic          ready_o, wr_en_o, start_message_o, end_message_o, error_o;
  logic [DW-1:0] wr_addr_o, start_addr_o, end_addr_o;
  logic [7:0]    wr_data_o;

  always #5 clk = ~clk;

  fix_msg_delimiter #(.DATA_WIDTH(DW), .MAX_MSG_LEN(MAXL)) dut (
    .clk            (clk),
    .rst            (rst),
    .byte_i         (byte_i),
    .byte_valid_i   (byte_valid_i),
    .ready_o        (ready_o),
    .full_i         (full_i),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .start_message_o(start_message_o),
    .start_addr_o   (start_addr_o),
    .end_message_o  (end_message_o),
    .end_addr_o     (end_addr_o),
    .error_o        (error_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int obs_wr, obs_start, obs_end, obs_err;

  // Reference model: the message seen so far, plus buffer pointer bookkeeping
  logic [7:0] msg[$];
  int         wp_m, sa_m;

  logic          nxt_wr_en, nxt_start, nxt_end, nxt_err;
  logic [DW-1:0] nxt_wr_addr, nxt_start_addr, nxt_end_addr;
  logic [7:0]    nxt_wr_data;
  logic          exp_wr_en, exp_start, exp_end, exp_err;
  logic [DW-1:0] exp_wr_addr, exp_start_addr, exp_end_addr;
  logic [7:0]    exp_wr_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_wr_en <= 0; exp_start <= 0; exp_end <= 0; exp_err <= 0;
      exp_wr_addr <= '0; exp_wr_data <= '0; exp_start_addr <= '0; exp_end_addr <= '0;
    end else begin
      exp_wr_en <= nxt_wr_en; exp_start <= nxt_start; exp_end <= nxt_end; exp_err <= nxt_err;
      exp_wr_addr <= nxt_wr_addr; exp_wr_data <= nxt_wr_data;
      exp_start_addr <= nxt_start_addr; exp_end_addr <= nxt_end_addr;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      n_cmp++;
      if (ready_o !== ~full_i) begin n_bad++; $display("FAIL ready got=%b want=%b t=%0t", ready_o, ~full_i, $time); end
      n_cmp++;
      if (wr_en_o !== exp_wr_en) begin n_bad++; $display("FAIL wr_en got=%b want=%b t=%0t", wr_en_o, exp_wr_en, $time); end
      if (exp_wr_en) begin
        n_cmp++;
        if (wr_addr_o !== exp_wr_addr || wr_data_o !== exp_wr_data) begin
          n_bad++;
          $display("FAIL write got=%0d/%h want=%0d/%h t=%0t", wr_addr_o, wr_data_o, exp_wr_addr, exp_wr_data, $time);
        end
      end
      n_cmp++;
      if ({start_message_o, start_addr_o} !== {exp_start, exp_start_addr}) begin
        n_bad++;
        $display("FAIL start got=%b/%0d want=%b/%0d t=%0t", start_message_o, start_addr_o, exp_start, exp_start_addr, $time);
      end
      n_cmp++;
      if ({end_message_o, end_addr_o} !== {exp_end, exp_end_addr}) begin
        n_bad++;
        $display("FAIL end got=%b/%0d want=%b/%0d t=%0t", end_message_o, end_addr_o, exp_end, exp_end_addr, $time);
      end
      n_cmp++;
      if (error_o !== exp_err) begin n_bad++; $display("FAIL error got=%b want=%b t=%0t", error_o, exp_err, $time); end
      if (wr_en_o) obs_wr++;
      if (start_message_o) obs_start++;
      if (end_message_o) obs_end++;
      if (error_o) obs_err++;
    end
  end

  task automatic model_reset();
    msg.delete();
    wp_m = 0; sa_m = 0;
    nxt_wr_en = 0; nxt_start = 0; nxt_end = 0; nxt_err = 0;
    nxt_wr_addr = '0; nxt_wr_data = '0; nxt_start_addr = '0; nxt_end_addr = '0;
  endtask

  // Classifies the accepted byte from the message text alone: which checksum
  // digits (if any) follow the most recent in-body "<SOH>10=" decides what is legal.
  task automatic model_accept(input logic [7:0] b);
    int n, ck;
    bit ok, last, hit;
    n = msg.size();
    if (n == 0) begin
      if (b == ASCII_8) begin
        sa_m = wp_m; msg.push_back(b);
        nxt_wr_en = 1; nxt_wr_addr = DW'(wp_m); nxt_wr_data = b;
        wp_m = (wp_m + 1) % NBUF;
      end
    end else if (n == 1) begin
      if (b == ASCII_EQ) begin
        msg.push_back(b);
        nxt_wr_en = 1; nxt_wr_addr = DW'(wp_m); nxt_wr_data = b;
        wp_m = (wp_m + 1) % NBUF;
        nxt_start = 1; nxt_start_addr = DW'(sa_m);
      end else if (b == ASCII_8) begin
        nxt_wr_en = 1; nxt_wr_addr = DW'(sa_m); nxt_wr_data = b;
        wp_m = (sa_m + 1) % NBUF;
      end else begin
        wp_m = sa_m; msg.delete();
      end
    end else begin
      ck = -1;
      for (int k = 0; k <= 3; k++) begin
        int p;
        p = n - 4 - k;
        if (ck < 0 && p >= 2) begin
          if (msg[p] == SOH && msg[p+1] == ASCII_1 && msg[p+2] == ASCII_0 && msg[p+3] == ASCII_EQ) begin
            hit = 1;
            for (int j = p + 4; j < n; j++) if (msg[j] < 8'h30 || msg[j] > 8'h39) hit = 0;
            if (hit) ck = k;
          end
        end
      end
      last = 0;
      if (n >= MAXL) ok = 0;
      else if (ck == 3) begin ok = (b == SOH); last = 1; end
      else if (ck >= 0) ok = (b >= 8'h30 && b <= 8'h39);
      else ok = 1;
      if (!ok) begin
        nxt_err = 1; wp_m = sa_m; msg.delete();
      end else begin
        nxt_wr_en = 1; nxt_wr_addr = DW'(wp_m); nxt_wr_data = b;
        if (last) begin
          nxt_end = 1; nxt_end_addr = DW'(wp_m); msg.delete();
        end else begin
          msg.push_back(b);
        end
        wp_m = (wp_m + 1) % NBUF;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input logic v, input logic f);
    byte_i = b; byte_valid_i = v; full_i = f;
    nxt_wr_en = 0; nxt_start = 0; nxt_end = 0; nxt_err = 0;
    if (v && !f) model_accept(b);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom % 8)
      0: return SOH;
      1: return ASCII_8;
      2: return ASCII_EQ;
      3: return ASCII_1;
      4: return ASCII_0;
      5: return 8'(8'h30 + $urandom % 10);
      6: return 8'(8'h41 + $urandom % 26);
      default: return 8'h78;
    endcase
  endfunction

  task automatic send_acc(input logic [7:0] b, input bit rnd);
    if (rnd) begin
      while ($urandom % 4 == 0) begin
        if ($urandom % 2) send(pick(), 1'($urandom % 2), 1'b1);
        else send(pick(), 1'b0, 1'($urandom % 2));
      end
    end
    send(b, 1'b1, 1'b0);
  endtask

  task automatic send_str(input string s, input bit rnd);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h7C) c = SOH;
      send_acc(c, rnd);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 0; byte_i = '0; byte_valid_i = 0; full_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    obs_wr = 0; obs_start = 0; obs_end = 0; obs_err = 0;
  endtask

  task automatic test_reset();
    model_reset();
    #2 rst = 0;
    #1;
    n_cmp++;
    if ({wr_en_o, wr_addr_o, wr_data_o, start_message_o, start_addr_o, end_message_o, end_addr_o, error_o} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got nonzero outputs");
    end
    do_reset();
    idle(3);
    n_cmp++;
    if (obs_wr + obs_start + obs_end + obs_err != 0) begin
      n_bad++; $display("FAIL reset_idle got=%0d events want=0", obs_wr + obs_start + obs_end + obs_err);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_str("8=FIX|10=123|", 0);
    idle(2);
    n_cmp++;
    if (obs_wr != 13 || obs_start != 1 || obs_end != 1 || obs_err != 0) begin
      n_bad++; $display("FAIL basic_counts got wr=%0d s=%0d e=%0d err=%0d want 13/1/1/0", obs_wr, obs_start, obs_end, obs_err);
    end
    n_cmp++;
    if (start_addr_o !== 5'd0 || end_addr_o !== 5'd12) begin
      n_bad++; $display("FAIL basic_addr got=%0d/%0d want=0/12", start_addr_o, end_addr_o);
    end
  endtask

  task automatic test_rewind();
    do_reset();
    send_str("x88=A|10=001|", 0);
    idle(2);
    n_cmp++;
    if (obs_wr != 12 || obs_start != 1 || obs_end != 1 || obs_err != 0) begin
      n_bad++; $display("FAIL rewind_counts got wr=%0d s=%0d e=%0d err=%0d want 12/1/1/0", obs_wr, obs_start, obs_end, obs_err);
    end
    n_cmp++;
    if (start_addr_o !== 5'd0 || end_addr_o !== 5'd10) begin
      n_bad++; $display("FAIL rewind_addr got=%0d/%0d want=0/10", start_addr_o, end_addr_o);
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send_str("8=A|10=1A3", 0);
    idle(1);
    n_cmp++;
    if (obs_err != 1 || obs_end != 0) begin
      n_bad++; $display("FAIL badck_err got err=%0d end=%0d want 1/0", obs_err, obs_end);
    end
    send_str("8=B|10=002|", 0);
    idle(2);
    n_cmp++;
    if (obs_start != 2 || obs_end != 1 || start_addr_o !== 5'd0 || end_addr_o !== 5'd10) begin
      n_bad++; $display("FAIL badck_retry got s=%0d e=%0d sa=%0d ea=%0d want 2/1/0/10", obs_start, obs_end, start_addr_o, end_addr_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_str("8=AB", 0);
    repeat (5) send(8'h43, 1'b1, 1'b1);
    n_cmp++;
    if (obs_wr != 4) begin
      n_bad++; $display("FAIL stall_writes got=%0d want=4", obs_wr);
    end
    send_str("C|10=123|", 0);
    idle(2);
    n_cmp++;
    if (obs_wr != 13 || obs_end != 1 || end_addr_o !== 5'd12) begin
      n_bad++; $display("FAIL stall_resume got wr=%0d e=%0d ea=%0d want 13/1/12", obs_wr, obs_end, end_addr_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    send_str("8=FIX|10=123|", 0);
    send_str("8=ABCDE|10=123|", 0);
    send_str("8=|10=000|", 0);
    idle(2);
    n_cmp++;
    if (obs_end != 3 || obs_err != 0 || start_addr_o !== 5'd28 || end_addr_o !== 5'd5) begin
      n_bad++; $display("FAIL wrap got e=%0d err=%0d sa=%0d ea=%0d want 3/0/28/5", obs_end, obs_err, start_addr_o, end_addr_o);
    end
  endtask

  task automatic test_oversize_and_async_reset();
    do_reset();
    send_str("8=", 0);
    repeat (28) send(8'h41, 1'b1, 1'b0);
    idle(2);
    n_cmp++;
    if (obs_err != 1 || obs_wr != MAXL || obs_end != 0) begin
      n_bad++; $display("FAIL oversize got err=%0d wr=%0d e=%0d want 1/%0d/0", obs_err, obs_wr, obs_end, MAXL);
    end
    send_str("8=", 0);
    n_cmp++;
    if (start_message_o !== 1'b1 || wr_en_o !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_pulse got start=%b wr=%b want 1/1", start_message_o, wr_en_o);
    end
    rst = 0;
    #1;
    n_cmp++;
    if ({wr_en_o, wr_addr_o, wr_data_o, start_message_o, start_addr_o, end_message_o, end_addr_o, error_o} !== '0) begin
      n_bad++; $display("FAIL async_reset got outputs not cleared");
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [7:0] pkt[$];
    do_reset();
    for (int it = 0; it < 40; it++) begin
      pkt.delete();
      repeat ($urandom % 3) pkt.push_back(pick());
      pkt.push_back(ASCII_8); pkt.push_back(ASCII_EQ);
      repeat ($urandom_range(0, 17)) pkt.push_back(($urandom % 5 == 0) ? SOH : 8'(8'h41 + $urandom % 26));
      pkt.push_back(SOH); pkt.push_back(ASCII_1); pkt.push_back(ASCII_0); pkt.push_back(ASCII_EQ);
      repeat (3) pkt.push_back(8'(8'h30 + $urandom % 10));
      pkt.push_back(SOH);
      if ($urandom % 4 == 0) pkt[$urandom % pkt.size()] = pick();
      foreach (pkt[i]) send_acc(pkt[i], 1'b1);
    end
    idle(2);
    n_cmp++;
    if (obs_end == 0) begin
      n_bad++; $display("FAIL random_no_ends got=0 want>0");
    end
  endtask

  initial begin
    model_reset();
    obs_wr = 0; obs_start = 0; obs_end = 0; obs_err = 0;
    test_reset();
    test_basic();
    test_rewind();
    test_bad_checksum();
    test_backpressure();
    test_wrap();
    test_oversize_and_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
